// File: rtl/fetch_control_pkg.sv
// Shared mips32 fetch constants: reset/bubble defaults, FSM encoding, PC helpers.
package fetch_control_pkg;

    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;
    localparam logic [31:0] DEFAULT_NOP_WORD = 32'h0000_0000;
    localparam logic [31:0] PC_STEP          = 32'd4;
    localparam int unsigned BUBBLE_CNT_W     = 16;

    typedef enum logic {
        ST_RUN   = 1'b0,
        ST_JWAIT = 1'b1
    } fetch_state_t;

    // Redirect targets are forced onto a word boundary.
    function automatic logic [31:0] align_word(input logic [31:0] addr);
        return addr & ~32'h0000_0003;
    endfunction

endpackage

// File: rtl/fetch_control_sat_counter.sv
// Width-parameterised saturating incrementer with synchronous clear.
module sat_counter #(
    parameter int unsigned WIDTH = 16
) (
    input  logic             clock,
    input  logic             clear,
    input  logic             inc,
    output logic [WIDTH-1:0] count
);

    always_ff @(posedge clock) begin
        if (clear) begin
            count <= '0;
        end else if (inc && (count != '1)) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/fetch_control.sv
// IF-stage PC and IF/ID register control with load-use stall, jump wait and redirect flush.
module fetch_control
    import fetch_control_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC,
    parameter logic [31:0] NOP_WORD = DEFAULT_NOP_WORD
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        pcWrite,
    input  logic        jumpStall,
    input  logic        ifIdFlush,
    input  logic [31:0] redirectPc,
    input  logic [31:0] instr,
    output logic [31:0] pcOut,
    output logic [31:0] ifIdInstr,
    output logic [31:0] ifIdPc,
    output logic        ifIdValid,
    output logic        jumpWait,
    output logic [15:0] bubbleCount
);

    fetch_state_t state;
    logic [31:0]  pc_next;
    logic         bubble;

    assign pc_next = pcOut + PC_STEP;

    // A bubble enters IF/ID on flush, every JWAIT cycle, or on jump entry from RUN.
    always_comb begin
        bubble = 1'b0;
        if (!reset) begin
            if (ifIdFlush || (state == ST_JWAIT)) begin
                bubble = 1'b1;
            end else if (pcWrite && jumpStall) begin
                bubble = 1'b1;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state     <= ST_RUN;
            jumpWait  <= 1'b0;
            pcOut     <= RESET_PC;
            ifIdInstr <= NOP_WORD;
            ifIdPc    <= '0;
            ifIdValid <= 1'b0;
        end else if (ifIdFlush) begin
            state     <= ST_RUN;
            jumpWait  <= 1'b0;
            pcOut     <= align_word(redirectPc);
            ifIdInstr <= NOP_WORD;
            ifIdValid <= 1'b0;
        end else if (state == ST_JWAIT) begin
            ifIdInstr <= NOP_WORD;
            ifIdValid <= 1'b0;
        end else if (!pcWrite) begin
            state <= ST_RUN;
        end else if (jumpStall) begin
            state     <= ST_JWAIT;
            jumpWait  <= 1'b1;
            ifIdInstr <= NOP_WORD;
            ifIdValid <= 1'b0;
        end else begin
            pcOut     <= pc_next;
            ifIdInstr <= instr;
            ifIdPc    <= pc_next;
            ifIdValid <= 1'b1;
        end
    end

    sat_counter #(
        .WIDTH(BUBBLE_CNT_W)
    ) u_bubble_cnt (
        .clock(clock),
        .clear(reset),
        .inc  (bubble),
        .count(bubbleCount)
    );

endmodule

// File: tb/tb_fetch_control.sv
// Directed bench for fetch_control: advance, stall, jump wait, flush, reset, PC wrap, saturation.
module tb_fetch_control;

    logic        clock = 1'b0;
    logic        reset;
    logic        pcWrite;
    logic        jumpStall;
    logic        ifIdFlush;
    logic [31:0] redirectPc;
    logic [31:0] instr;

    logic [31:0] pcOut, ifIdInstr, ifIdPc;
    logic        ifIdValid, jumpWait;
    logic [15:0] bubbleCount;

    logic [31:0] w_pcOut, w_ifIdInstr, w_ifIdPc;
    logic        w_ifIdValid, w_jumpWait;
    logic [15:0] w_bubbleCount;

    int total = 0;
    int bad   = 0;

    always #5 clock = ~clock;

    fetch_control dut (
        .clock(clock), .reset(reset), .pcWrite(pcWrite), .jumpStall(jumpStall),
        .ifIdFlush(ifIdFlush), .redirectPc(redirectPc), .instr(instr),
        .pcOut(pcOut), .ifIdInstr(ifIdInstr), .ifIdPc(ifIdPc), .ifIdValid(ifIdValid),
        .jumpWait(jumpWait), .bubbleCount(bubbleCount)
    );

    fetch_control #(
        .RESET_PC(32'hFFFF_FFFC),
        .NOP_WORD(32'h0000_0000)
    ) dut_wrap (
        .clock(clock), .reset(reset), .pcWrite(pcWrite), .jumpStall(jumpStall),
        .ifIdFlush(ifIdFlush), .redirectPc(redirectPc), .instr(instr),
        .pcOut(w_pcOut), .ifIdInstr(w_ifIdInstr), .ifIdPc(w_ifIdPc), .ifIdValid(w_ifIdValid),
        .jumpWait(w_jumpWait), .bubbleCount(w_bubbleCount)
    );

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        total++;
        assert (observed === expected)
        else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_pc"},     pcOut,              32'h0);
        check({tag, "_instr"},  ifIdInstr,          32'h0);
        check({tag, "_ifidpc"}, ifIdPc,             32'h0);
        check({tag, "_valid"},  {31'b0, ifIdValid}, 32'h0);
        check({tag, "_jw"},     {31'b0, jumpWait},  32'h0);
        check({tag, "_bc"},     {16'b0, bubbleCount}, 32'h0);
    endtask

    initial begin
        reset = 1'b1; pcWrite = 1'b1; jumpStall = 1'b0; ifIdFlush = 1'b0;
        redirectPc = 32'h0; instr = 32'h2001_0005;

        // Reset state, including the high RESET_PC instance
        tick();
        check_reset_state("rst");
        check("wrap_rst_pc", w_pcOut, 32'hFFFF_FFFC);

        // Three advances
        reset = 1'b0;
        tick();
        check("adv1_ifidpc", ifIdPc, 32'h4);
        check("wrap_pc",     w_pcOut, 32'h0);
        check("wrap_ifidpc", w_ifIdPc, 32'h0);
        tick();
        tick();
        check("adv3_pc",     pcOut, 32'hC);
        check("adv3_ifidpc", ifIdPc, 32'hC);
        check("adv3_valid",  {31'b0, ifIdValid}, 32'h1);
        check("adv3_instr",  ifIdInstr, 32'h2001_0005);

        // Load-use stall at pc 0x10
        tick();
        check("pre_stall_pc", pcOut, 32'h10);
        instr = 32'hDEAD_BEEF; pcWrite = 1'b0;
        tick();
        tick();
        check("stall_pc",     pcOut, 32'h10);
        check("stall_instr",  ifIdInstr, 32'h2001_0005);
        check("stall_ifidpc", ifIdPc, 32'h10);
        check("stall_valid",  {31'b0, ifIdValid}, 32'h1);
        check("stall_bc",     {16'b0, bubbleCount}, 32'h0);
        pcWrite = 1'b1;

        // Jump wait from pc 0x20, then redirect to 0x103
        reset = 1'b1; tick(); reset = 1'b0;
        instr = 32'h1234_5678;
        for (int i = 0; i < 8; i++) tick();
        check("jw_pre_pc", pcOut, 32'h20);
        jumpStall = 1'b1;
        tick();
        check("jw_enter_jw",    {31'b0, jumpWait}, 32'h1);
        check("jw_enter_pc",    pcOut, 32'h20);
        check("jw_enter_valid", {31'b0, ifIdValid}, 32'h0);
        check("jw_enter_instr", ifIdInstr, 32'h0);
        check("jw_enter_bc",    {16'b0, bubbleCount}, 32'h1);
        jumpStall = 1'b0; pcWrite = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("jw_idle_jw", {31'b0, jumpWait}, 32'h1);
            check("jw_idle_pc", pcOut, 32'h20);
        end
        check("jw_idle_bc", {16'b0, bubbleCount}, 32'h4);
        pcWrite = 1'b1; ifIdFlush = 1'b1; redirectPc = 32'h0000_0103;
        tick();
        check("jw_flush_pc",    pcOut, 32'h100);
        check("jw_flush_valid", {31'b0, ifIdValid}, 32'h0);
        check("jw_flush_jw",    {31'b0, jumpWait}, 32'h0);
        check("jw_flush_bc",    {16'b0, bubbleCount}, 32'h5);
        ifIdFlush = 1'b0;
        tick();
        check("jw_run_pc",    pcOut, 32'h104);
        check("jw_run_valid", {31'b0, ifIdValid}, 32'h1);

        // Flush dominates simultaneous jumpStall and pcWrite=0
        jumpStall = 1'b1; pcWrite = 1'b0; ifIdFlush = 1'b1; redirectPc = 32'h40;
        tick();
        check("prio_pc", pcOut, 32'h40);
        check("prio_jw", {31'b0, jumpWait}, 32'h0);
        check("prio_bc", {16'b0, bubbleCount}, 32'h6);
        jumpStall = 1'b0; pcWrite = 1'b1; ifIdFlush = 1'b0;
        tick();
        check("prio_run_pc", pcOut, 32'h44);

        // Reset while in JWAIT, with a flush request also present
        jumpStall = 1'b1;
        tick();
        tick();
        check("rjw_jw", {31'b0, jumpWait}, 32'h1);
        reset = 1'b1; ifIdFlush = 1'b1; redirectPc = 32'h200;
        tick();
        check_reset_state("rjw");
        reset = 1'b0; ifIdFlush = 1'b0; jumpStall = 1'b0;
        tick();
        check("rjw_after_pc",    pcOut, 32'h4);
        check("rjw_after_valid", {31'b0, ifIdValid}, 32'h1);
        check("rjw_after_jw",    {31'b0, jumpWait}, 32'h0);
        check("rjw_after_bc",    {16'b0, bubbleCount}, 32'h0);

        // Bubble counter saturation
        reset = 1'b1; tick(); reset = 1'b0;
        jumpStall = 1'b1;
        tick();
        jumpStall = 1'b0;
        for (int i = 0; i < 65533; i++) tick();
        check("sat_fffe", {16'b0, bubbleCount}, 32'hFFFE);
        tick();
        check("sat_ffff", {16'b0, bubbleCount}, 32'hFFFF);
        for (int i = 0; i < 6; i++) tick();
        check("sat_hold", {16'b0, bubbleCount}, 32'hFFFF);
        check("sat_jw",   {31'b0, jumpWait}, 32'h1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/fetch_control.md
FETCH_CONTROL -- requirements
Module: fetch_control

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000, meaning PC value loaded on reset.
REQ-002 SHALL have parameter NOP_WORD, default 32'h0000_0000, meaning instruction word inserted as a bubble.
REQ-003 SHALL have port clock  in  1  sole clock; all state updates on rising edge.
REQ-004 SHALL have port reset  in  1  synchronous, active-high reset.
REQ-005 SHALL have port pcWrite  in  1  0 = load-use stall (hold PC and IF/ID).
REQ-006 SHALL have port jumpStall  in  1  jump detected in ID; freeze PC and emit bubbles until redirect.
REQ-007 SHALL have port ifIdFlush  in  1  taken branch/jump resolved; squash IF/ID and redirect PC.
REQ-008 SHALL have port redirectPc  in  32  target PC, sampled when ifIdFlush=1.
REQ-009 SHALL have port instr  in  32  instruction-memory read data for address pcOut (combinational read).
REQ-010 SHALL have port pcOut  out  32  current fetch PC, registered.
REQ-011 SHALL have port ifIdInstr  out  32  IF/ID instruction register.
REQ-012 SHALL have port ifIdPc  out  32  IF/ID PC+4 register.
REQ-013 SHALL have port ifIdValid  out  1  1 = IF/ID holds a real instruction, 0 = bubble.
REQ-014 SHALL have port jumpWait  out  1  1 while FSM is in JWAIT.
REQ-015 SHALL have port bubbleCount  out  16  saturating count of bubbles inserted since reset.

Function
REQ-016 SHALL implement a two-state FSM: RUN, JWAIT.
REQ-017 SHALL resolve per-cycle priority as: reset > ifIdFlush > pcWrite=0 (RUN only) > jumpStall > normal advance.
REQ-018 SHALL, on normal advance in RUN: pcOut<=pcOut+4, ifIdInstr<=instr, ifIdPc<=pcOut+4, ifIdValid<=1.
REQ-019 SHALL, on pcWrite=0 in RUN without ifIdFlush: hold pcOut, ifIdInstr, ifIdPc, ifIdValid; stay RUN; bubbleCount unchanged.
REQ-020 SHALL, on jumpStall=1 in RUN with pcWrite=1 and ifIdFlush=0: hold pcOut, load IF/ID with NOP_WORD / valid 0, go JWAIT, increment bubbleCount.
REQ-021 SHALL, in JWAIT without ifIdFlush: hold pcOut, load bubble each cycle, increment bubbleCount each cycle; pcWrite and jumpStall ignored.
REQ-022 SHALL, on ifIdFlush=1 in either state: pcOut<={redirectPc[31:2],2'b00}, load bubble into IF/ID, increment bubbleCount, go RUN.
REQ-023 SHALL make ifIdFlush and jumpStall in the same RUN cycle behave as ifIdFlush alone (stay RUN).
REQ-024 SHALL wrap PC increment modulo 2^32 (32'hFFFF_FFFC+4 -> 32'h0000_0000).
REQ-025 SHALL saturate bubbleCount at 16'hFFFF, never wrapping.
REQ-026 SHALL drive jumpWait=1 exactly when state is JWAIT (registered, no combinational input path).
REQ-027 SHALL have zero-cycle IF latency: instruction at pcOut appears on ifIdInstr after the next advancing edge.

Reset
REQ-028 SHALL, when reset=1 at a rising edge, set pcOut=RESET_PC, ifIdInstr=NOP_WORD, ifIdPc=0, ifIdValid=0, state=RUN, jumpWait=0, bubbleCount=0, regardless of other inputs.
REQ-029 SHALL abandon any JWAIT in progress on reset mid-operation, with no residual bubble or redirect afterwards.

Structure
REQ-030 SHALL take NOP_WORD default, RESET_PC default and the RUN/JWAIT state encodings from the shared mips32 constants include file.
REQ-031 SHALL instantiate one sub-module, sat_counter (width-parameterised saturating incrementer with synchronous clear), for bubbleCount.

Verification
REQ-032 SHALL cover: reset then 3 advancing cycles, instr=32'h2001_0005 -> pcOut=0x0C, ifIdPc=0x0C, ifIdValid=1, ifIdInstr=32'h2001_0005.
REQ-033 SHALL cover: pcOut=0x10, pcWrite=0 for 2 cycles -> pcOut stays 0x10, IF/ID unchanged, bubbleCount unchanged.
REQ-034 SHALL cover: pcOut=0x20, jumpStall=1 one cycle, 3 idle cycles, then ifIdFlush=1 with redirectPc=0x0000_0103 -> jumpWait=1 for 4 cycles, pcOut=0x100, ifIdValid=0, bubbleCount=5, state RUN.
REQ-035 SHALL cover: jumpStall=1, pcWrite=0 and ifIdFlush=1 in the same cycle, redirectPc=0x40 -> pcOut=0x40, state RUN, one bubble counted.
REQ-036 SHALL cover: RESET_PC=32'hFFFF_FFFC, one advance -> pcOut=0x0; separately, reset asserted while in JWAIT -> all REQ-028 values next cycle.
REQ-037 SHALL cover: bubbleCount preloaded near saturation via 65,540 JWAIT cycles -> bubbleCount=16'hFFFF, holds.
